// File: rtl/parameters_pkg.sv
// parameters_pkg: shared widths, modulus and opcode constants for the modular add/sub datapath.
package parameters_pkg;
  localparam int DATA_WIDTH = 448;
  localparam logic [DATA_WIDTH-1:0] MODULUS = {{223{1'b1}}, 1'b0, {224{1'b1}}};
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/limb_addsub.sv
// limb_addsub: one LIMB-wide add or subtract with carry/borrow in and out.
module limb_addsub #(
  parameter int LIMB = 64
) (
  input  logic [LIMB-1:0] i_x,
  input  logic [LIMB-1:0] i_y,
  input  logic            i_cin,
  input  logic            i_sub,
  output logic [LIMB-1:0] o_s,
  output logic            o_cout
);
  logic [LIMB:0] w_sum;
  // Subtract result is negative exactly when the top bit is set, so it doubles as borrow-out.
  assign w_sum  = i_sub ? {1'b0, i_x} - {1'b0, i_y} - {{LIMB{1'b0}}, i_cin}
                        : {1'b0, i_x} + {1'b0, i_y} + {{LIMB{1'b0}}, i_cin};
  assign o_s    = w_sum[LIMB-1:0];
  assign o_cout = w_sum[LIMB];
endmodule

// File: rtl/mod_addsub.sv
// mod_addsub: limb-serial (a +/- b) mod MOD; one pass for the raw sum/difference,
// a second pass for the correction by MOD, then a final select.
module mod_addsub
  import parameters_pkg::*;
#(
  parameter int              WIDTH = DATA_WIDTH,
  parameter int              LIMB  = 64,
  parameter logic [WIDTH-1:0] MOD  = WIDTH'(MODULUS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy
);
  localparam int N  = WIDTH / LIMB;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PASS1 = 2'd1;
  localparam logic [1:0] S_PASS2 = 2'd2;
  localparam logic [1:0] S_FINAL = 2'd3;

  if (WIDTH % LIMB != 0) begin : g_bad_limb
    $error("mod_addsub: WIDTH must be a multiple of LIMB");
  end

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_m, r_raw, r_t, r_result;
  logic             r_op, r_c, r_c1, r_done;
  logic [LIMB-1:0]  w_x, w_y, w_s;
  logic             w_p1, w_sub, w_cout, w_last, w_use_t;

  assign w_p1    = r_state == S_PASS1;
  assign w_last  = r_cnt == CW'(N - 1);
  assign w_x     = w_p1 ? r_a[LIMB-1:0] : r_raw[LIMB-1:0];
  assign w_y     = w_p1 ? r_b[LIMB-1:0] : r_m[LIMB-1:0];
  // Second pass applies the opposite operation with MOD to undo overflow/underflow.
  assign w_sub   = w_p1 ? r_op : ~r_op;
  assign w_use_t = r_op ? r_c1 : (r_c1 | ~r_c);

  limb_addsub #(.LIMB(LIMB)) u_limb (
    .i_x(w_x), .i_y(w_y), .i_cin(r_c), .i_sub(w_sub), .o_s(w_s), .o_cout(w_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_m      <= '0;
      r_raw    <= '0;
      r_t      <= '0;
      r_result <= '0;
      r_op     <= 1'b0;
      r_c      <= 1'b0;
      r_c1     <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (start && !r_done) begin
          r_a     <= a;
          r_b     <= b;
          r_m     <= MOD;
          r_op    <= op;
          r_c     <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_PASS1;
        end
      end else if (r_state == S_PASS1) begin
        r_a   <= r_a >> LIMB;
        r_b   <= r_b >> LIMB;
        r_raw <= WIDTH'({w_s, r_raw} >> LIMB);
        r_c   <= w_last ? 1'b0 : w_cout;
        r_c1  <= w_cout;
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        if (w_last) r_state <= S_PASS2;
      end else if (r_state == S_PASS2) begin
        r_raw <= WIDTH'({r_raw[LIMB-1:0], r_raw} >> LIMB);
        r_m   <= r_m >> LIMB;
        r_t   <= WIDTH'({w_s, r_t} >> LIMB);
        r_c   <= w_cout;
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        if (w_last) r_state <= S_FINAL;
      end else begin
        r_result <= w_use_t ? r_t : r_raw;
        r_done   <= 1'b1;
        r_state  <= S_IDLE;
      end
    end
  end

  assign result = r_result;
  assign done   = r_done;
  assign busy   = (r_state != S_IDLE) | r_done;
endmodule
